// File: rtl/mux_pkg.sv
// Shared definitions for the mux stage and its upstream round-robin scheduler.
// Combinational content only.
// No flow control.
package mux_pkg;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = $clog2(N);

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {S_EMPTY, S_FULL} sched_state_e;
endpackage

// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between N requesters, the scheduler and the downstream mux.
// Wires only, no latency.
// The scheduler drives req_ready_o. The downstream side drives out_ready_i.
// grant_cnt_o exists only when MUX_SCHED_STATS_EN is defined.
interface mux_rr_sched_if #(
  parameter int WIDTH = mux_pkg::WIDTH,
  parameter int N     = mux_pkg::N,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]     req_valid_i;
  logic [WIDTH-1:0] req_data_i [N];
  logic [N-1:0]     req_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic [SEL_W-1:0] out_sel_o;
  logic             out_ready_i;
`ifdef MUX_SCHED_STATS_EN
  logic [CNT_W-1:0] grant_cnt_o [N];
`endif

  // Scheduler side
  modport slave (
    input  req_valid_i, req_data_i, out_ready_i,
`ifdef MUX_SCHED_STATS_EN
    output grant_cnt_o,
`endif
    output req_ready_o, out_valid_o, out_data_o, out_sel_o
  );

  // Requester / downstream side
  modport master (
    output req_valid_i, req_data_i, out_ready_i,
`ifdef MUX_SCHED_STATS_EN
    input  grant_cnt_o,
`endif
    input  req_ready_o, out_valid_o, out_data_o, out_sel_o
  );
endinterface

// File: rtl/mux_rr_sched_rr_arbiter.sv
// Round-robin pick: the first asserted request at or after ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No flow control. The caller decides whether to act on the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);
  localparam int SW = $clog2(N);

  // Scan offsets from farthest to nearest so the closest request to ptr wins
  always_comb begin
    int idx;
    idx         = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = SW'(idx);
      end
    end
  end
endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler feeding a one-deep output register (payload + select) for the mux.
// Latency: a payload accepted at edge k is on out_* after edge k. Throughput is one per cycle.
// Backpressure: ready goes to a single requester only when the register is empty or being popped.
// Optional per-requester saturating grant counters are enabled by `define MUX_SCHED_STATS_EN.
module mux_rr_sched #(
  parameter int WIDTH = mux_pkg::WIDTH,
  parameter int N     = mux_pkg::N,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  mux_rr_sched_if.slave bus
);
  import mux_pkg::*;

  localparam int SEL_W = $clog2(N);

  sched_state_e     state_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             load;
  logic             take;
  logic [N-1:0]     ready_d;

  rr_arbiter #(.N(N)) u_arb (
    .req_i       (bus.req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // The register may take a new payload when it is empty or is being popped this cycle
  assign load = (state_q == S_EMPTY) || bus.out_ready_i;
  assign take = rst_n && load && gnt_valid;

  // One-hot ready to the winner. It is held low in reset so no handshake completes.
  always_comb begin
    ready_d = '0;
    if (take) ready_d[gnt_idx] = 1'b1;
  end

  // The pointer moves to the slot after the winner and wraps explicitly for non-power-of-two N
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SEL_W'(1);
  end

  // Output register FSM: the register fills on grant and drains on pop without a new grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      if (gnt_valid) begin
        state_q <= S_FULL;
        data_q  <= bus.req_data_i[gnt_idx];
        sel_q   <= gnt_idx;
        ptr_q   <= ptr_d;
      end else begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign bus.req_ready_o = ready_d;
  assign bus.out_valid_o = (state_q == S_FULL);
  assign bus.out_data_o  = data_q;
  assign bus.out_sel_o   = sel_q;

`ifdef MUX_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [N];

  // Count accepted payloads per requester. Each counter sticks at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (bus.req_valid_i[i] && ready_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign bus.grant_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_rr_sched_if #(.WIDTH(8), .N(4), .CNT_W(2)) bus4 ();
  mux_rr_sched_if #(.WIDTH(8), .N(3), .CNT_W(2)) bus3 ();

  mux_rr_sched #(.WIDTH(8), .N(4), .CNT_W(2)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  mux_rr_sched #(.WIDTH(8), .N(3), .CNT_W(2)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus4.out_valid_o !== 1'b0 || bus4.out_sel_o !== 2'd0 || bus4.out_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_state4: valid=%b sel=%0d data=%h, want 0/0/00",
               bus4.out_valid_o, bus4.out_sel_o, bus4.out_data_o);
    end
    checks++;
    if (bus3.out_valid_o !== 1'b0 || bus3.out_sel_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state3: valid=%b sel=%0d, want 0/0", bus3.out_valid_o, bus3.out_sel_o);
    end
    // Fill the register with sel=2 and hold it with no pop
    rst_n = 1'b1;
    bus4.req_valid_i   = 4'b0100;
    bus4.req_data_i[2] = 8'h77;
    bus4.out_ready_i   = 1'b0;
    step();
    checks++;
    if (bus4.out_valid_o !== 1'b1 || bus4.out_sel_o !== 2'd2 || bus4.out_data_o !== 8'h77) begin
      errors++;
      $display("FAIL reset_fill: valid=%b sel=%0d data=%h, want 1/2/77",
               bus4.out_valid_o, bus4.out_sel_o, bus4.out_data_o);
    end
    // Assert reset while the register is full and the request is still valid
    rst_n = 1'b0;
    bus4.req_valid_i = 4'b1111;
    #1;
    checks++;
    if (bus4.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_comb: got %b, want 0000", bus4.req_ready_o);
    end
    step();
    checks++;
    if (bus4.out_valid_o !== 1'b0 || bus4.out_sel_o !== 2'd0 || bus4.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_midfull: valid=%b sel=%0d ready=%b, want 0/0/0000",
               bus4.out_valid_o, bus4.out_sel_o, bus4.req_ready_o);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
    logic [3:0] exp_rdy;
    rst_n = 1'b1;
    bus4.req_valid_i = 4'b1111;
    bus4.out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) bus4.req_data_i[i] = 8'(c * 16 + i);
      exp_sel  = 2'(c % 4);
      exp_data = 8'(c * 16 + (c % 4));
      exp_rdy  = 4'b0001 << (c % 4);
      #1;
      checks++;
      if (bus4.req_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL fair_ready[%0d]: got %b, want %b", c, bus4.req_ready_o, exp_rdy);
      end
      step();
      checks++;
      if (bus4.out_valid_o !== 1'b1 || bus4.out_sel_o !== exp_sel || bus4.out_data_o !== exp_data) begin
        errors++;
        $display("FAIL fair_out[%0d]: valid=%b sel=%0d data=%h, want 1/%0d/%h",
                 c, bus4.out_valid_o, bus4.out_sel_o, bus4.out_data_o, exp_sel, exp_data);
      end
    end
  endtask

  task automatic test_backpressure();
    bus4.req_valid_i   = 4'b0100;
    bus4.req_data_i[2] = 8'h5A;
    bus4.out_ready_i   = 1'b1;
    step();
    checks++;
    if (bus4.out_sel_o !== 2'd2 || bus4.out_data_o !== 8'h5A) begin
      errors++;
      $display("FAIL bp_load: sel=%0d data=%h, want 2/5a", bus4.out_sel_o, bus4.out_data_o);
    end
    bus4.out_ready_i = 1'b0;
    bus4.req_valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) bus4.req_data_i[i] = 8'(8'hE0 + c * 4 + i);
      #1;
      checks++;
      if (bus4.req_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, want 0000", c, bus4.req_ready_o);
      end
      step();
      checks++;
      if (bus4.out_valid_o !== 1'b1 || bus4.out_sel_o !== 2'd2 || bus4.out_data_o !== 8'h5A) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h, want 1/2/5a",
                 c, bus4.out_valid_o, bus4.out_sel_o, bus4.out_data_o);
      end
    end
    bus4.out_ready_i   = 1'b1;
    bus4.req_data_i[3] = 8'hC3;
    #1;
    checks++;
    if (bus4.req_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, want 1000", bus4.req_ready_o);
    end
    step();
    checks++;
    if (bus4.out_sel_o !== 2'd3 || bus4.out_data_o !== 8'hC3) begin
      errors++;
      $display("FAIL bp_release_out: sel=%0d data=%h, want 3/c3", bus4.out_sel_o, bus4.out_data_o);
    end
  endtask

  task automatic test_sparse();
    bus4.req_valid_i = 4'b0000;
    bus4.out_ready_i = 1'b1;
    step();
    checks++;
    if (bus4.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sparse_drain: valid=%b, want 0", bus4.out_valid_o);
    end
    bus4.req_valid_i   = 4'b0010;
    bus4.req_data_i[1] = 8'h11;
    step();
    bus4.req_valid_i = 4'b0000;
    checks++;
    if (bus4.out_valid_o !== 1'b1 || bus4.out_sel_o !== 2'd1 || bus4.out_data_o !== 8'h11) begin
      errors++;
      $display("FAIL sparse_full: valid=%b sel=%0d data=%h, want 1/1/11",
               bus4.out_valid_o, bus4.out_sel_o, bus4.out_data_o);
    end
    step();
    checks++;
    if (bus4.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sparse_empty: valid=%b, want 0", bus4.out_valid_o);
    end
    // The pointer should now sit at 2
    bus4.req_valid_i = 4'b1111;
    #1;
    checks++;
    if (bus4.req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL sparse_ptr: ready=%b, want 0100", bus4.req_ready_o);
    end
    step();
    bus4.req_valid_i = 4'b0000;
    step();
  endtask

  task automatic test_wrap_n3();
    logic [2:0] exp_rdy [3];
    logic [1:0] exp_sel [3];
    exp_rdy[0] = 3'b100; exp_sel[0] = 2'd2;
    exp_rdy[1] = 3'b001; exp_sel[1] = 2'd0;
    exp_rdy[2] = 3'b100; exp_sel[2] = 2'd2;
    bus3.out_ready_i   = 1'b1;
    bus3.req_valid_i   = 3'b001;
    bus3.req_data_i[0] = 8'hA0;
    bus3.req_data_i[2] = 8'hA2;
    step();
    checks++;
    if (bus3.out_sel_o !== 2'd0 || bus3.out_data_o !== 8'hA0) begin
      errors++;
      $display("FAIL wrap_setup: sel=%0d data=%h, want 0/a0", bus3.out_sel_o, bus3.out_data_o);
    end
    bus3.req_valid_i = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus3.req_ready_o !== exp_rdy[c]) begin
        errors++;
        $display("FAIL wrap_ready[%0d]: got %b, want %b", c, bus3.req_ready_o, exp_rdy[c]);
      end
      step();
      checks++;
      if (bus3.out_sel_o !== exp_sel[c] || bus3.out_data_o !== (exp_sel[c] == 2'd2 ? 8'hA2 : 8'hA0)) begin
        errors++;
        $display("FAIL wrap_sel[%0d]: sel=%0d data=%h, want %0d", c, bus3.out_sel_o, bus3.out_data_o, exp_sel[c]);
      end
    end
    // After granting 2 the pointer wraps to 0, so requester 0 wins next
    bus3.req_valid_i = 3'b111;
    #1;
    checks++;
    if (bus3.req_ready_o !== 3'b001) begin
      errors++;
      $display("FAIL wrap_ptr0: ready=%b, want 001", bus3.req_ready_o);
    end
    bus3.req_valid_i = 3'b000;
    step();
  endtask

`ifdef MUX_SCHED_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus4.req_valid_i = 4'b0001;
    bus4.out_ready_i = 1'b1;
    step();
    step();
    checks++;
    if (bus4.grant_cnt_o[0] !== 2'd2) begin
      errors++;
      $display("FAIL stats_two: cnt0=%0d, want 2", bus4.grant_cnt_o[0]);
    end
    step();
    step();
    step();
    bus4.req_valid_i = 4'b0000;
    checks++;
    if (bus4.grant_cnt_o[0] !== 2'd3 || bus4.grant_cnt_o[1] !== 2'd0 ||
        bus4.grant_cnt_o[2] !== 2'd0 || bus4.grant_cnt_o[3] !== 2'd0) begin
      errors++;
      $display("FAIL stats_sat: cnt=%0d/%0d/%0d/%0d, want 3/0/0/0", bus4.grant_cnt_o[0],
               bus4.grant_cnt_o[1], bus4.grant_cnt_o[2], bus4.grant_cnt_o[3]);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus4.grant_cnt_o[0] !== 2'd0) begin
      errors++;
      $display("FAIL stats_reset: cnt0=%0d, want 0", bus4.grant_cnt_o[0]);
    end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus4.req_valid_i = '0;
    bus4.out_ready_i = 1'b0;
    bus3.req_valid_i = '0;
    bus3.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) bus4.req_data_i[i] = '0;
    for (int i = 0; i < 3; i++) bus3.req_data_i[i] = '0;

    test_reset();
    test_fairness();
    test_backpressure();
    test_sparse();
    test_wrap_n3();
`ifdef MUX_SCHED_STATS_EN
    test_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
